// File: rtl/psum_pkg.sv
`default_nettype none
//============================================================================
// Module : psum_pkg
// Brief  : Shared types and constants for the partial-sum accumulator.
// Rev    : 1.0 - initial release
//============================================================================
package psum_pkg;

   localparam int DEF_ACC_W = 32;
   localparam int DEF_CNT_W = 8;

   typedef logic signed [DEF_ACC_W-1:0] acc_t;

   typedef struct packed {
      acc_t                 sum;
      logic [DEF_CNT_W-1:0] count;
      logic                 ovf;
   } fifo_entry_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   localparam acc_t ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
   localparam acc_t ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

   // Same-sign operands whose result flips sign.
   function automatic logic signedOvf(input logic aSign, input logic bSign, input logic sSign);
      return (aSign == bSign) && (sSign != aSign);
   endfunction

endpackage
`default_nettype wire

// File: rtl/psum_accumulator_if.sv
`default_nettype none
//============================================================================
// Module : psum_accumulator_if
// Brief  : Input and output valid/ready streams of the psum accumulator.
// Rev    : 1.0 - initial release
//============================================================================
interface psum_accumulator_if #(
   parameter int ACC_W = 32,
   parameter int CNT_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [ACC_W-1:0] in_psum;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0]        out_count;
   logic                    out_ovf;

   modport master (
      output in_valid, in_psum, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_psum, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface
`default_nettype wire

// File: rtl/psum_out_fifo.sv
`default_nettype none
//============================================================================
// Module : psum_out_fifo
// Brief  : Two-entry synchronous FIFO built from two enabled register slots.
// Rev    : 1.0 - initial release
//============================================================================
module psum_out_fifo
   import psum_pkg::*;
#(
   parameter type T = fifo_entry_t
)(
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_push,
   input  wire T     i_data,
   input  wire logic i_pop,
   output T          o_data,
   output logic      o_full,
   output logic      o_empty,
   output logic [1:0] o_count
);

   logic       r_wrPtr;
   logic       r_rdPtr;
   logic [1:0] r_count;
   logic       w_doPush;
   logic       w_doPop;
   logic [1:0] w_slotEn;
   T           w_slotQ [2];

   assign w_doPop  = i_pop && (r_count != 2'd0);
   // A full FIFO can still take a write into the slot being drained this cycle.
   assign w_doPush = i_push && ((r_count != 2'd2) || w_doPop);

   generate
      for (genvar g = 0; g < 2; g++) begin : g_slot
         assign w_slotEn[g] = w_doPush && (r_wrPtr == 1'(g));
         psum_reg #(.T(T)) u_slot (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_slotEn[g]),
            .i_d  (i_data),
            .o_q  (w_slotQ[g])
         );
      end
   endgenerate

   assign o_data  = w_slotQ[r_rdPtr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= ~r_wrPtr;
         end
         if (w_doPop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/psum_reg.sv
`default_nettype none
//============================================================================
// Module : psum_reg
// Brief  : Enabled register with asynchronous active-high clear.
// Rev    : 1.0 - initial release
//============================================================================
module psum_reg #(
   parameter type T = logic
)(
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_en,
   input  wire T     i_d,
   output T          o_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_q <= '0;
      end else if (i_en) begin
         o_q <= i_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
//============================================================================
// Module : psum_accumulator
// Brief  : Accumulates per-tile column partial sums over a pass and queues
//          the result in a 2-entry output FIFO. Optional macro
//          PSUM_ACC_SATURATE_EN clamps on signed overflow instead of wrapping.
// Rev    : 1.0 - initial release
//============================================================================
module psum_accumulator
   import psum_pkg::*;
#(
   parameter int ACC_W      = 32,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 2
)(
   input wire logic          clk,
   input wire logic          rst,
   psum_accumulator_if.slave bus
);

   generate
      if (FIFO_DEPTH != 2) begin : g_depthCheck
         $error("psum_accumulator: FIFO_DEPTH must be 2");
      end
   endgenerate

   typedef struct packed {
      logic signed [ACC_W-1:0] sum;
      logic [CNT_W-1:0]        count;
      logic                    ovf;
   } entry_t;

   localparam logic [CNT_W-1:0]        CNT_MAX = '1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   acc_state_e              r_state;
   acc_state_e              w_stateNext;
   logic signed [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0]        r_tileCnt;
   logic                    r_ovfSticky;

   logic signed [ACC_W-1:0] w_base;
   logic signed [ACC_W-1:0] w_rawSum;
   logic signed [ACC_W-1:0] w_sum;
   logic [CNT_W-1:0]        w_cntBase;
   logic [CNT_W-1:0]        w_cntInc;
   logic                    w_ovfBase;
   logic                    w_stepOvf;
   logic                    w_ovfAll;
   logic                    w_accept;
   logic                    w_push;
   logic                    w_load;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [1:0]              w_count;
   entry_t                  w_pushData;
   entry_t                  w_head;

   assign bus.in_ready = (w_count < 2'd2);
   assign w_accept     = bus.in_valid && !w_full;
   assign w_pop        = bus.out_valid && bus.out_ready;

   // A pass starts from zero, so IDLE and ACCUM share one adder.
   assign w_base    = (r_state == ACCUM) ? r_acc       : '0;
   assign w_cntBase = (r_state == ACCUM) ? r_tileCnt   : '0;
   assign w_ovfBase = (r_state == ACCUM) ? r_ovfSticky : 1'b0;

   assign w_rawSum  = w_base + bus.in_psum;
   assign w_stepOvf = signedOvf(w_base[ACC_W-1], bus.in_psum[ACC_W-1], w_rawSum[ACC_W-1]);
   assign w_ovfAll  = w_ovfBase | w_stepOvf;
   assign w_cntInc  = (w_cntBase == CNT_MAX) ? CNT_MAX : w_cntBase + 1'b1;

`ifdef PSUM_ACC_SATURATE_EN
   assign w_sum = w_stepOvf ? (w_base[ACC_W-1] ? SAT_MIN : SAT_MAX) : w_rawSum;
`else
   assign w_sum = w_rawSum;
`endif

   always_comb begin
      w_pushData.sum   = w_sum;
      w_pushData.count = w_cntInc;
      w_pushData.ovf   = w_ovfAll;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_push      = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (bus.in_last) begin
                  w_push = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_stateNext = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (w_accept) begin
               if (bus.in_last) begin
                  w_push      = 1'b1;
                  w_stateNext = IDLE;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_tileCnt   <= '0;
         r_ovfSticky <= 1'b0;
      end else if (w_load) begin
         r_acc       <= w_sum;
         r_tileCnt   <= w_cntInc;
         r_ovfSticky <= w_ovfAll;
      end
   end

   psum_out_fifo #(.T(entry_t)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_pushData),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign bus.out_valid = !w_empty;
   assign bus.out_sum   = w_head.sum;
   assign bus.out_count = w_head.count;
   assign bus.out_ovf   = w_head.ovf;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
//============================================================================
// Module : tb_psum_accumulator
// Brief  : Directed and random stimulus against a pass-level arithmetic model.
// Rev    : 1.0 - initial release
//============================================================================
module tb_psum_accumulator;

   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   psum_accumulator_if #(.ACC_W(32), .CNT_W(8)) busA ();
   psum_accumulator_if #(.ACC_W(32), .CNT_W(2)) busB ();

   psum_accumulator #(.ACC_W(32), .CNT_W(8), .FIFO_DEPTH(2)) dutA (
      .clk (clk), .rst (rst), .bus (busA)
   );
   psum_accumulator #(.ACC_W(32), .CNT_W(2), .FIFO_DEPTH(2)) dutB (
      .clk (clk), .rst (rst), .bus (busB)
   );

   int errors = 0;
   int checks = 0;
   int beats  = 0;

   typedef struct {
      logic [31:0] sum;
      logic [31:0] cnt;
      logic        ovf;
   } exp_t;

   exp_t   expQ[$];
   longint mAcc    = 0;
   int     mCnt    = 0;
   logic   mOvf    = 1'b0;
   bit     mInPass = 1'b0;

   bit   randReady   = 1'b0;
   logic forcedReady = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pass-level reference: exact integer sum, overflow judged against the 32-bit range.
   function automatic void modelAccept(input longint v, input bit last);
      longint      s;
      logic [63:0] bits;
      exp_t        e;
      if (!mInPass) begin
         mAcc = 0;
         mCnt = 0;
         mOvf = 1'b0;
      end
      s = mAcc + v;
      if (s > MAXV || s < MINV) begin
         mOvf = 1'b1;
`ifdef PSUM_ACC_SATURATE_EN
         s = (s > MAXV) ? MAXV : MINV;
`else
         s = (s > MAXV) ? s - 64'sd4294967296 : s + 64'sd4294967296;
`endif
      end
      mAcc = s;
      mCnt = (mCnt < 255) ? mCnt + 1 : 255;
      if (last) begin
         bits  = s;
         e.sum = bits[31:0];
         e.cnt = mCnt;
         e.ovf = mOvf;
         expQ.push_back(e);
         mInPass = 1'b0;
      end else begin
         mInPass = 1'b1;
      end
   endfunction

   task automatic send(input logic [31:0] v, input bit last);
      int waited = 0;
      busA.in_valid = 1'b1;
      busA.in_psum  = v;
      busA.in_last  = last;
      @(negedge clk);
      while (!busA.in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      checks++;
      assert (waited < 200) else begin
         errors++;
         $error("FAIL send_timeout: observed in_ready=0 for %0d cycles expected=accept", waited);
      end
      @(posedge clk);
      #1;
      busA.in_valid = 1'b0;
      busA.in_psum  = $urandom;
      busA.in_last  = 1'($urandom_range(0, 1));
      if (waited < 200) modelAccept(longint'(signed'(v)), last);
   endtask

   task automatic setReady(input logic r);
      forcedReady = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      busA.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         busA.out_ready = randReady ? ($urandom_range(0, 2) != 0) : forcedReady;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && busA.out_valid && busA.out_ready) begin
            checks++;
            assert (expQ.size() != 0) else begin
               errors++;
               $error("FAIL beat_unexpected: observed sum=%0h expected=no beat", busA.out_sum);
            end
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               chk("beat_sum",   32'(busA.out_sum),   e.sum);
               chk("beat_count", 32'(busA.out_count), e.cnt);
               chk("beat_ovf",   32'(busA.out_ovf),   32'(e.ovf));
               beats++;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         base;
      logic [31:0] v;
      int         len;

      busA.in_valid = 1'b0; busA.in_psum = '0; busA.in_last = 1'b0;
      busB.in_valid = 1'b0; busB.in_psum = '0; busB.in_last = 1'b0;
      busB.out_ready = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready",  32'(busA.in_ready),  32'd1);
      chk("rst_out_valid", 32'(busA.out_valid), 32'd0);
      chk("rst_out_sum",   32'(busA.out_sum),   32'd0);
      chk("rst_out_count", 32'(busA.out_count), 32'd0);
      chk("rst_out_ovf",   32'(busA.out_ovf),   32'd0);
      chk("rstB_in_ready", 32'(busB.in_ready),  32'd1);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Single-tile pass, one-cycle latency
      setReady(1'b0);
      send(32'd5, 1'b1);
      @(negedge clk);
      chk("single_valid", 32'(busA.out_valid), 32'd1);
      chk("single_sum",   32'(busA.out_sum),   32'd5);
      chk("single_count", 32'(busA.out_count), 32'd1);
      chk("single_ovf",   32'(busA.out_ovf),   32'd0);
      setReady(1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("single_drained", 32'(busA.out_valid), 32'd0);
      @(posedge clk); #1;

      // Three-tile pass
      base = beats;
      send(32'd10, 1'b0);
      send(-32'sd3, 1'b0);
      send(32'd7, 1'b1);
      repeat (4) @(negedge clk);
      chk("three_beats", 32'(beats - base), 32'd1);
      @(posedge clk); #1;

      // Backpressure with a full FIFO
      setReady(1'b0);
      base = beats;
      send(32'd1, 1'b1);
      send(32'd2, 1'b1);
      busA.in_valid = 1'b1; busA.in_psum = 32'd3; busA.in_last = 1'b1;
      @(negedge clk);
      chk("bp_in_ready",  32'(busA.in_ready),  32'd0);
      chk("bp_head_sum",  32'(busA.out_sum),   32'd1);
      @(negedge clk);
      chk("bp_hold_ready", 32'(busA.in_ready), 32'd0);
      chk("bp_hold_valid", 32'(busA.out_valid), 32'd1);
      chk("bp_hold_sum",   32'(busA.out_sum),  32'd1);
      setReady(1'b1);
      @(negedge clk);
      chk("bp_full_ready_low", 32'(busA.in_ready), 32'd0);
      @(posedge clk); #1;
      send(32'd3, 1'b1);
      repeat (5) @(negedge clk);
      chk("bp_beats", 32'(beats - base), 32'd3);
      @(posedge clk); #1;

      // Positive overflow
      send(32'h7FFF_FFFF, 1'b0);
      send(32'd1, 1'b1);
      @(negedge clk);
`ifdef PSUM_ACC_SATURATE_EN
      chk("ovf_sum", 32'(busA.out_sum), 32'h7FFF_FFFF);
`else
      chk("ovf_sum", 32'(busA.out_sum), 32'h8000_0000);
`endif
      chk("ovf_flag", 32'(busA.out_ovf), 32'd1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;

      // Random passes with random output backpressure
      randReady = 1'b1;
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 6);
         for (int t = 0; t < len; t++) begin
            case ($urandom_range(0, 2))
               0:       v = 32'($urandom_range(0, 200)) - 32'd100;
               1:       v = $urandom;
               default: v = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 15))
                                                        : 32'h8000_0000 + 32'($urandom_range(0, 15));
            endcase
            send(v, (t == len - 1));
         end
      end
      randReady = 1'b0;
      setReady(1'b1);
      repeat (6) @(negedge clk);
      chk("rand_drained", 32'(expQ.size()), 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset mid-pass with a result still queued
      setReady(1'b0);
      send(32'd8, 1'b1);
      send(32'd4, 1'b0);
      send(32'd6, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(busA.out_valid), 32'd0);
      chk("midrst_in_ready",  32'(busA.in_ready),  32'd1);
      chk("midrst_out_count", 32'(busA.out_count), 32'd0);
      expQ.delete();
      mInPass = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      setReady(1'b1);
      base = beats;
      send(32'd9, 1'b1);
      repeat (3) @(negedge clk);
      chk("midrst_beats", 32'(beats - base), 32'd1);
      @(posedge clk); #1;

      // Tile counter saturation on the narrow-counter instance
      busB.in_valid = 1'b1;
      busB.in_psum  = 32'd1;
      for (int i = 0; i < 5; i++) begin
         busB.in_last = (i == 4);
         @(negedge clk);
         chk("sat_in_ready", 32'(busB.in_ready), 32'd1);
         @(posedge clk); #1;
      end
      busB.in_valid = 1'b0;
      busB.in_last  = 1'b0;
      @(negedge clk);
      chk("sat_valid", 32'(busB.out_valid), 32'd1);
      chk("sat_sum",   32'(busB.out_sum),   32'd5);
      chk("sat_count", 32'(busB.out_count), 32'd3);
      chk("sat_ovf",   32'(busB.out_ovf),   32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
